ctrl_unit: RTL and testbench
============================

CTRL_UNIT -- requirements
Module: ctrl_unit

Interface
REQ-001 Parameter: RESET_STALL, default 2, number of INIT cycles after reset release before first fetch (range 1..15).
REQ-002 CLK  in  1  single clock; all state changes on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous, active-low.
REQ-004 IR  in  32  current instruction, stable from EXEC entry until next FETCH.
REQ-005 BR_EQ / BR_LT / BR_LTU  in  1 each  rs1==rs2, signed rs1<rs2, unsigned rs1<rs2.
REQ-006 MEM_READY  in  1  memory completes current fetch/load/store this cycle.
REQ-007 INTR  in  1  external interrupt request, level; INT_EN  in  1  interrupt enable.
REQ-008 MEM_RDEN1  out  1  instruction fetch request; MEM_RDEN2  out  1  data load request; MEM_WE  out  1  data store request.
REQ-009 PC_WE  out  1  PC update strobe; RF_WE  out  1  register-file write strobe.
REQ-010 ALU_FUN  out  4  ALU opcode: ADD 0000, SUB 1000, OR 0110, AND 0111, XOR 0100, SRL 0101, SLL 0001, SRA 1101, SLT 0010, SLTU 0011, LUI-copy 1001.
REQ-011 SRCA_SEL  out  2  0 rs1, 1 U-imm; SRCB_SEL  out  2  0 rs2, 1 I-imm, 2 S-imm, 3 PC.
REQ-012 PC_SEL  out  3  0 PC+4, 1 JALR, 2 branch, 3 JAL, 4 trap vector; RF_WR_SEL  out  2  0 PC+4, 2 load data, 3 ALU result.
REQ-013 INT_TAKEN  out  1  trap entry strobe; ILLEGAL  out  1  unsupported opcode flag.

Function
REQ-014 FSM states INIT, FETCH, EXEC, WB, TRAP; all outputs combinational from state and IR; every output 0 unless stated.
REQ-015 INIT: 4-bit counter counts RESET_STALL cycles, then FETCH.
REQ-016 FETCH: MEM_RDEN1=1 held until MEM_READY; MEM_READY=1 -> EXEC next cycle; MEM_READY same cycle as FETCH entry is legal (1-cycle fetch).
REQ-017 EXEC decode: R-type ALU_FUN={IR[30],IR[14:12]}; OP-IMM ALU_FUN={IR[14:12]==101 ? IR[30] : 0, IR[14:12]}; LUI 1001 with SRCA_SEL=1; AUIPC ADD, SRCA_SEL=1, SRCB_SEL=3; load/store/JAL/JALR/branch ADD.
REQ-018 EXEC, ALU ops/LUI/AUIPC: RF_WE=1, RF_WR_SEL=3, PC_WE=1, PC_SEL=0, single cycle.
REQ-019 EXEC, JAL/JALR: RF_WE=1, RF_WR_SEL=0, PC_WE=1, PC_SEL=3/1, SRCB_SEL=1 for JALR.
REQ-020 EXEC, branch: PC_WE=1; PC_SEL=2 if funct3 condition (BEQ,BNE,BLT,BGE,BLTU,BGEU) true from BR_* else 0; no RF_WE.
REQ-021 EXEC, store: MEM_WE=1, SRCB_SEL=2 held until MEM_READY; PC_WE=1 only in the MEM_READY cycle.
REQ-022 EXEC, load: MEM_RDEN2=1, SRCB_SEL=1 held until MEM_READY, then WB; WB: RF_WE=1, RF_WR_SEL=2, PC_WE=1, PC_SEL=0, one cycle.
REQ-023 Unsupported opcode in EXEC: ILLEGAL=1 one cycle, no RF_WE/MEM_WE/PC_WE, next state TRAP regardless of INT_EN.
REQ-024 Instruction completion = cycle with PC_WE=1 in EXEC/WB; then INTR&INT_EN -> TRAP, else FETCH; INTR outside completion cycles ignored until next completion.
REQ-025 TRAP: INT_TAKEN=1, PC_WE=1, PC_SEL=4 for exactly one cycle, then FETCH; INTR in TRAP does not re-trap.
REQ-026 rd=x0 not special-cased; RF_WE asserted normally.

Reset
REQ-027 RST_N low asynchronously forces INIT, counter 0; all outputs 0 while RST_N low, including mid-fetch/mid-store.
REQ-028 RST_N deassertion synchronous to CLK by system; first MEM_RDEN1 exactly RESET_STALL+1 edges after release.

Structure
REQ-029 Shared package ctrl_pkg holds opcode constants, alu_fun_t enum (REQ-010 encodings), state_t enum, mux-select encodings.
REQ-030 Combinational decode in sub-module ctrl_dcdr (IR, BR_*, state -> selects/ALU_FUN/ILLEGAL); FSM and counter in ctrl_unit.

Verification
REQ-031 Reset release, RESET_STALL=2, MEM_READY=1 -> MEM_RDEN1 first high at edge 3; all outputs 0 before.
REQ-032 IR=0x40208033 (SUB x0,x1,x2) -> EXEC: ALU_FUN=1000, RF_WE=1, RF_WR_SEL=3, PC_WE=1; 0x4020D093 (SRAI) -> ALU_FUN=1101, SRCB_SEL=1.
REQ-033 LW with MEM_READY low 3 cycles -> MEM_RDEN2 high 4 cycles, WB RF_WE=1 RF_WR_SEL=2 once; SW same -> MEM_WE 4 cycles, PC_WE only last.
REQ-034 BNE with BR_EQ=0 -> PC_SEL=2; BR_EQ=1 -> PC_SEL=0; BGEU with BR_LTU=0 -> PC_SEL=2.
REQ-035 INTR=1, INT_EN=1 during ADD completion -> TRAP next cycle, INT_TAKEN=1 PC_SEL=4 one cycle; INT_EN=0 -> FETCH; IR=0x0000007F -> ILLEGAL, then TRAP.
REQ-036 RST_N low during store wait -> MEM_WE falls without clock edge; restart per REQ-031.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control unit: opcodes, ALU codes, FSM states,
// mux-select encodings and the decoded control bundle.
package ctrl_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SLL  = 4'b0001,
    ALU_SLT  = 4'b0010,
    ALU_SLTU = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_OR   = 4'b0110,
    ALU_AND  = 4'b0111,
    ALU_SUB  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SRA  = 4'b1101
  } alu_fun_t;

  typedef enum logic [2:0] {
    ST_INIT, ST_FETCH, ST_EXEC, ST_WB, ST_TRAP
  } state_t;

  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_UIMM = 2'd1;

  localparam logic [1:0] SRCB_RS2  = 2'd0;
  localparam logic [1:0] SRCB_IIMM = 2'd1;
  localparam logic [1:0] SRCB_SIMM = 2'd2;
  localparam logic [1:0] SRCB_PC   = 2'd3;

  localparam logic [2:0] PC_PLUS4  = 3'd0;
  localparam logic [2:0] PC_JALR   = 3'd1;
  localparam logic [2:0] PC_BRANCH = 3'd2;
  localparam logic [2:0] PC_JAL    = 3'd3;
  localparam logic [2:0] PC_TRAP   = 3'd4;

  localparam logic [1:0] WR_PC4  = 2'd0;
  localparam logic [1:0] WR_LOAD = 2'd2;
  localparam logic [1:0] WR_ALU  = 2'd3;

  typedef struct packed {
    logic       mem_rden1;
    logic       mem_rden2;
    logic       mem_we;
    logic       pc_we;
    logic       rf_we;
    logic [3:0] alu_fun;
    logic [1:0] srca_sel;
    logic [1:0] srcb_sel;
    logic [2:0] pc_sel;
    logic [1:0] rf_wr_sel;
    logic       int_taken;
    logic       illegal;
    logic       is_load;   // EXEC of a load: FSM moves to WB on MEM_READY
  } ctrl_sig_t;

  // Branch condition from funct3 and the comparator flags.
  function automatic logic br_taken(input logic [2:0] f3, input logic eq,
                                    input logic lt, input logic ltu);
    case (f3)
      3'b000:  br_taken = eq;
      3'b001:  br_taken = !eq;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = !lt;
      3'b110:  br_taken = ltu;
      3'b111:  br_taken = !ltu;
      default: br_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_unit_dcdr.sv
// Combinational decode: state + instruction + branch flags -> control bundle.
module ctrl_dcdr
  import ctrl_pkg::*;
(
  input  logic [31:0] ir_i,
  input  logic        br_eq_i,
  input  logic        br_lt_i,
  input  logic        br_ltu_i,
  input  logic        mem_ready_i,
  input  state_t      state_i,
  output ctrl_sig_t   sig_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       unused_ir;

  assign opcode    = ir_i[6:0];
  assign funct3    = ir_i[14:12];
  assign unused_ir = ^{ir_i[31], ir_i[29:15], ir_i[11:7]};

  // Output decode; everything defaults to 0 so INIT is fully quiet.
  always_comb begin
    sig_o = '0;
    unique case (state_i)
      ST_FETCH: sig_o.mem_rden1 = 1'b1;
      ST_EXEC: begin
        case (opcode)
          OPC_OP: begin
            sig_o.alu_fun   = {ir_i[30], funct3};
            sig_o.rf_we     = 1'b1;
            sig_o.rf_wr_sel = WR_ALU;
            sig_o.pc_we     = 1'b1;
          end
          OPC_OPIMM: begin
            // Only shifts use bit 30 (SRLI vs SRAI); ADDI etc. ignore it.
            sig_o.alu_fun   = {(funct3 == 3'b101) & ir_i[30], funct3};
            sig_o.srcb_sel  = SRCB_IIMM;
            sig_o.rf_we     = 1'b1;
            sig_o.rf_wr_sel = WR_ALU;
            sig_o.pc_we     = 1'b1;
          end
          OPC_LUI: begin
            sig_o.alu_fun   = ALU_LUI;
            sig_o.srca_sel  = SRCA_UIMM;
            sig_o.rf_we     = 1'b1;
            sig_o.rf_wr_sel = WR_ALU;
            sig_o.pc_we     = 1'b1;
          end
          OPC_AUIPC: begin
            sig_o.srca_sel  = SRCA_UIMM;
            sig_o.srcb_sel  = SRCB_PC;
            sig_o.rf_we     = 1'b1;
            sig_o.rf_wr_sel = WR_ALU;
            sig_o.pc_we     = 1'b1;
          end
          OPC_JAL: begin
            sig_o.rf_we     = 1'b1;
            sig_o.rf_wr_sel = WR_PC4;
            sig_o.pc_we     = 1'b1;
            sig_o.pc_sel    = PC_JAL;
          end
          OPC_JALR: begin
            sig_o.srcb_sel  = SRCB_IIMM;
            sig_o.rf_we     = 1'b1;
            sig_o.rf_wr_sel = WR_PC4;
            sig_o.pc_we     = 1'b1;
            sig_o.pc_sel    = PC_JALR;
          end
          OPC_BRANCH: begin
            sig_o.pc_we  = 1'b1;
            sig_o.pc_sel = br_taken(funct3, br_eq_i, br_lt_i, br_ltu_i)
                           ? PC_BRANCH : PC_PLUS4;
          end
          OPC_STORE: begin
            sig_o.mem_we   = 1'b1;
            sig_o.srcb_sel = SRCB_SIMM;
            sig_o.pc_we    = mem_ready_i;
          end
          OPC_LOAD: begin
            sig_o.mem_rden2 = 1'b1;
            sig_o.srcb_sel  = SRCB_IIMM;
            sig_o.is_load   = 1'b1;
          end
          default: sig_o.illegal = 1'b1;
        endcase
      end
      ST_WB: begin
        sig_o.rf_we     = 1'b1;
        sig_o.rf_wr_sel = WR_LOAD;
        sig_o.pc_we     = 1'b1;
      end
      ST_TRAP: begin
        sig_o.int_taken = 1'b1;
        sig_o.pc_we     = 1'b1;
        sig_o.pc_sel    = PC_TRAP;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ctrl_unit.sv
// Multicycle control FSM: reset stall, fetch, execute, load writeback, trap.
module ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int RESET_STALL = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ir_i,
  input  logic        br_eq_i,
  input  logic        br_lt_i,
  input  logic        br_ltu_i,
  input  logic        mem_ready_i,
  input  logic        intr_i,
  input  logic        int_en_i,
  output logic        mem_rden1_o,
  output logic        mem_rden2_o,
  output logic        mem_we_o,
  output logic        pc_we_o,
  output logic        rf_we_o,
  output logic [3:0]  alu_fun_o,
  output logic [1:0]  srca_sel_o,
  output logic [1:0]  srcb_sel_o,
  output logic [2:0]  pc_sel_o,
  output logic [1:0]  rf_wr_sel_o,
  output logic        int_taken_o,
  output logic        illegal_o
);

  localparam logic [3:0] STALL = 4'(RESET_STALL);

  state_t    state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  ctrl_sig_t sig;
  logic      trap_req;

  ctrl_dcdr u_dcdr (
    .ir_i        (ir_i),
    .br_eq_i     (br_eq_i),
    .br_lt_i     (br_lt_i),
    .br_ltu_i    (br_ltu_i),
    .mem_ready_i (mem_ready_i),
    .state_i     (state_q),
    .sig_o       (sig)
  );

  assign trap_req = intr_i & int_en_i;

  // State and stall counter; reset drops straight to a quiet INIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; interrupts are only sampled on instruction completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        if (cnt_q == STALL) state_d = ST_FETCH;
        else                cnt_d   = cnt_q + 4'd1;
      end
      ST_FETCH: if (mem_ready_i) state_d = ST_EXEC;
      ST_EXEC: begin
        if (sig.illegal)                     state_d = ST_TRAP;
        else if (sig.pc_we)                  state_d = trap_req ? ST_TRAP : ST_FETCH;
        else if (sig.is_load && mem_ready_i) state_d = ST_WB;
      end
      ST_WB:   state_d = trap_req ? ST_TRAP : ST_FETCH;
      ST_TRAP: state_d = ST_FETCH;
      default: state_d = ST_INIT;
    endcase
  end

  assign mem_rden1_o = sig.mem_rden1;
  assign mem_rden2_o = sig.mem_rden2;
  assign mem_we_o    = sig.mem_we;
  assign pc_we_o     = sig.pc_we;
  assign rf_we_o     = sig.rf_we;
  assign alu_fun_o   = sig.alu_fun;
  assign srca_sel_o  = sig.srca_sel;
  assign srcb_sel_o  = sig.srcb_sel;
  assign pc_sel_o    = sig.pc_sel;
  assign rf_wr_sel_o = sig.rf_wr_sel;
  assign int_taken_o = sig.int_taken;
  assign illegal_o   = sig.illegal;

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: directed scenarios plus randomized instruction stream
// checked against a per-instruction behavioural model.
module tb_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] ir = '0;
  logic        br_eq = 0, br_lt = 0, br_ltu = 0;
  logic        mem_ready = 0, intr = 0, int_en = 0;
  logic        mem_rden1_o, mem_rden2_o, mem_we_o, pc_we_o, rf_we_o;
  logic [3:0]  alu_fun_o;
  logic [1:0]  srca_sel_o, srcb_sel_o, rf_wr_sel_o;
  logic [2:0]  pc_sel_o;
  logic        int_taken_o, illegal_o;

  int nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  ctrl_unit #(.RESET_STALL(2)) dut (
    .clk(clk), .rst_n(rst_n), .ir_i(ir), .br_eq_i(br_eq), .br_lt_i(br_lt),
    .br_ltu_i(br_ltu), .mem_ready_i(mem_ready), .intr_i(intr), .int_en_i(int_en),
    .mem_rden1_o(mem_rden1_o), .mem_rden2_o(mem_rden2_o), .mem_we_o(mem_we_o),
    .pc_we_o(pc_we_o), .rf_we_o(rf_we_o), .alu_fun_o(alu_fun_o),
    .srca_sel_o(srca_sel_o), .srcb_sel_o(srcb_sel_o), .pc_sel_o(pc_sel_o),
    .rf_wr_sel_o(rf_wr_sel_o), .int_taken_o(int_taken_o), .illegal_o(illegal_o)
  );

  logic any_out;
  assign any_out = |{mem_rden1_o, mem_rden2_o, mem_we_o, pc_we_o, rf_we_o, alu_fun_o,
                     srca_sel_o, srcb_sel_o, pc_sel_o, rf_wr_sel_o, int_taken_o, illegal_o};

  // Per-instruction observations gathered by exec_instr.
  int         o_fetch, o_mem, o_pcwe, o_rfwe, o_trap, o_ill, o_rfsel, o_cpcsel, o_tpcsel;
  logic [3:0] s_alu;
  logic [1:0] s_srca, s_srcb;
  logic       s_pcwe;
  bit         o_to;

  // Reset pulse then release at a falling edge; reports the edge of first fetch.
  task automatic do_reset(output int fe, output bit early, output bit low_nz);
    fe = 0; early = 0; low_nz = 0;
    #2 rst_n = 1'b0; mem_ready = 1'b1; intr = 1'b0; ir = '0;
    #1 if (any_out) low_nz = 1;
    @(negedge clk); if (any_out) low_nz = 1;
    @(negedge clk); if (any_out) low_nz = 1;
    rst_n = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (mem_rden1_o) begin fe = e; break; end
      if (any_out) early = 1;
    end
  endtask

  // Runs one instruction from its first fetch cycle (posedge+1) to the next fetch.
  task automatic exec_instr(input logic [31:0] ins, input int fw, input int mw,
                            input logic iv, input logic ev, input logic eq,
                            input logic lt, input logic ltu);
    bit started;
    started = 0;
    ir = ins; intr = iv; int_en = ev; br_eq = eq; br_lt = lt; br_ltu = ltu;
    o_fetch = 0; o_mem = 0; o_pcwe = 0; o_rfwe = 0; o_trap = 0; o_ill = 0;
    o_rfsel = -1; o_cpcsel = -1; o_tpcsel = -1; o_to = 0;
    s_alu = 'x; s_srca = 'x; s_srcb = 'x; s_pcwe = 'x;
    for (int it = 0; ; it++) begin
      if (mem_rden1_o && started) break;
      if (it >= 60) begin o_to = 1; break; end
      if (mem_rden1_o)                 mem_ready = (o_fetch == fw);
      else if (mem_rden2_o || mem_we_o) mem_ready = (o_mem == mw);
      else                             mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!started && mem_rden1_o) o_fetch++;
      else begin
        if (!started) begin
          started = 1;
          s_alu = alu_fun_o; s_srca = srca_sel_o; s_srcb = srcb_sel_o; s_pcwe = pc_we_o;
        end
        if (mem_rden2_o || mem_we_o) o_mem++;
        if (int_taken_o) begin o_trap++; o_tpcsel = int'(pc_sel_o); end
        else if (pc_we_o) begin o_pcwe++; o_cpcsel = int'(pc_sel_o); end
        if (rf_we_o) begin o_rfwe++; o_rfsel = int'(rf_wr_sel_o); end
        if (illegal_o) o_ill++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    int fe; bit early, low_nz;
    do_reset(fe, early, low_nz);
    nvec++; if (low_nz !== 1'b0) begin nerr++; $display("FAIL reset_low_outputs: got %0d want 0", low_nz); end
    nvec++; if (early !== 1'b0) begin nerr++; $display("FAIL reset_init_quiet: got %0d want 0", early); end
    nvec++; if (fe !== 3) begin nerr++; $display("FAIL reset_first_fetch_edge: got %0d want 3", fe); end
  endtask

  task automatic test_alu();
    exec_instr(32'h40208033, 0, 0, 0, 0, 0, 0, 0);
    nvec++; if (s_alu !== 4'b1000) begin nerr++; $display("FAIL sub_alu: got %b want 1000", s_alu); end
    nvec++; if (o_rfwe !== 1 || o_rfsel !== 3) begin nerr++; $display("FAIL sub_rf: got we=%0d sel=%0d want 1/3", o_rfwe, o_rfsel); end
    nvec++; if (s_pcwe !== 1'b1 || o_cpcsel !== 0) begin nerr++; $display("FAIL sub_pc: got we=%0d sel=%0d want 1/0", s_pcwe, o_cpcsel); end
    exec_instr(32'h4020D093, 1, 0, 0, 0, 0, 0, 0);
    nvec++; if (s_alu !== 4'b1101 || s_srcb !== 2'd1) begin nerr++; $display("FAIL srai: got alu=%b srcb=%0d want 1101/1", s_alu, s_srcb); end
    nvec++; if (o_fetch !== 2) begin nerr++; $display("FAIL fetch_wait: got %0d want 2", o_fetch); end
  endtask

  task automatic test_load_store();
    exec_instr(32'h00002003, 0, 3, 0, 0, 0, 0, 0);
    nvec++; if (o_mem !== 4) begin nerr++; $display("FAIL lw_rden2_cycles: got %0d want 4", o_mem); end
    nvec++; if (o_rfwe !== 1 || o_rfsel !== 2) begin nerr++; $display("FAIL lw_wb: got we=%0d sel=%0d want 1/2", o_rfwe, o_rfsel); end
    exec_instr(32'h00002023, 0, 3, 0, 0, 0, 0, 0);
    nvec++; if (o_mem !== 4) begin nerr++; $display("FAIL sw_we_cycles: got %0d want 4", o_mem); end
    nvec++; if (o_pcwe !== 1 || s_pcwe !== 1'b0 || o_rfwe !== 0) begin nerr++; $display("FAIL sw_pcwe: got cnt=%0d first=%0d rf=%0d want 1/0/0", o_pcwe, s_pcwe, o_rfwe); end
  endtask

  task automatic test_branch();
    exec_instr(32'h00001063, 0, 0, 0, 0, 0, 0, 0);
    nvec++; if (o_cpcsel !== 2) begin nerr++; $display("FAIL bne_taken: got %0d want 2", o_cpcsel); end
    exec_instr(32'h00001063, 0, 0, 0, 0, 1, 0, 0);
    nvec++; if (o_cpcsel !== 0 || o_rfwe !== 0) begin nerr++; $display("FAIL bne_not_taken: got sel=%0d rf=%0d want 0/0", o_cpcsel, o_rfwe); end
    exec_instr(32'h00007063, 0, 0, 0, 0, 0, 1, 0);
    nvec++; if (o_cpcsel !== 2) begin nerr++; $display("FAIL bgeu_taken: got %0d want 2", o_cpcsel); end
  endtask

  task automatic test_intr();
    exec_instr(32'h00000033, 2, 0, 1, 1, 0, 0, 0);
    nvec++; if (o_trap !== 1 || o_tpcsel !== 4) begin nerr++; $display("FAIL intr_trap: got n=%0d sel=%0d want 1/4", o_trap, o_tpcsel); end
    exec_instr(32'h00000033, 0, 0, 1, 0, 0, 0, 0);
    nvec++; if (o_trap !== 0) begin nerr++; $display("FAIL intr_masked: got %0d want 0", o_trap); end
    exec_instr(32'h0000007F, 0, 0, 0, 0, 0, 0, 0);
    nvec++; if (o_ill !== 1 || o_trap !== 1 || o_pcwe !== 0 || o_rfwe !== 0) begin
      nerr++; $display("FAIL illegal: got ill=%0d trap=%0d pcwe=%0d rf=%0d want 1/1/0/0", o_ill, o_trap, o_pcwe, o_rfwe);
    end
  endtask

  task automatic test_reset_mid_store();
    int fe; bit early, low_nz, seen;
    seen = 0;
    ir = 32'h00002023; intr = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_we_o) begin seen = 1; break; end
      mem_ready = mem_rden1_o;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    nvec++; if (seen !== 1'b1 || mem_we_o !== 1'b1) begin nerr++; $display("FAIL store_wait_reached: got %0d want 1", mem_we_o); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (mem_we_o !== 1'b0 || any_out !== 1'b0) begin nerr++; $display("FAIL async_reset_store: got we=%0d any=%0d want 0/0", mem_we_o, any_out); end
    do_reset(fe, early, low_nz);
    nvec++; if (fe !== 3 || early !== 1'b0) begin nerr++; $display("FAIL restart_fetch_edge: got %0d early=%0d want 3/0", fe, early); end
  endtask

  task automatic test_random();
    logic [31:0] ins; logic [6:0] op; logic [2:0] f3;
    int fw, mw, k;
    logic iv, ev, eq, lt, ltu;
    bit r, im, lui, aui, jal, jalr, br, ld, st, ill, tk;
    int e_alu, e_srca, e_srcb, e_rfwe, e_rfsel, e_cpcsel, e_trap;
    logic [6:0] opcs [10];
    opcs = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h7F};
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 9);
      ins = $urandom;
      ins[6:0] = opcs[k];
      if (k == 9 && $urandom_range(0, 1) == 1) ins[6:0] = 7'h73;
      if (k == 6 && ins[14:13] == 2'b01) ins[14] = 1'b1;
      fw = $urandom_range(0, 2); mw = $urandom_range(0, 3);
      iv = ($urandom_range(0, 3) == 0); ev = 1'($urandom_range(0, 1));
      eq = 1'($urandom_range(0, 1)); lt = 1'($urandom_range(0, 1)); ltu = 1'($urandom_range(0, 1));
      exec_instr(ins, fw, mw, iv, ev, eq, lt, ltu);
      op = ins[6:0]; f3 = ins[14:12];
      r = (op == 7'h33); im = (op == 7'h13); lui = (op == 7'h37); aui = (op == 7'h17);
      jal = (op == 7'h6F); jalr = (op == 7'h67); br = (op == 7'h63);
      ld = (op == 7'h03); st = (op == 7'h23);
      ill = !(r | im | lui | aui | jal | jalr | br | ld | st);
      case (f3)
        3'd0: tk = eq;   3'd1: tk = !eq;
        3'd4: tk = lt;   3'd5: tk = !lt;
        3'd6: tk = ltu;  3'd7: tk = !ltu;
        default: tk = 0;
      endcase
      e_alu  = r ? {ins[30], f3} : im ? {(f3 == 3'd5) & ins[30], f3} : lui ? 9 : 0;
      e_srca = (lui | aui) ? 1 : 0;
      e_srcb = (im | jalr | ld) ? 1 : st ? 2 : aui ? 3 : 0;
      e_rfwe = (r | im | lui | aui | jal | jalr | ld) ? 1 : 0;
      e_rfsel = ld ? 2 : (jal | jalr) ? 0 : 3;
      e_cpcsel = jal ? 3 : jalr ? 1 : (br && tk) ? 2 : 0;
      e_trap = (ill || (iv && ev)) ? 1 : 0;
      nvec++; if (o_to !== 0) begin nerr++; $display("FAIL rnd%0d_timeout ir=%h: got %0d want 0", n, ins, o_to); end
      nvec++; if (o_fetch !== fw + 1) begin nerr++; $display("FAIL rnd%0d_fetch ir=%h: got %0d want %0d", n, ins, o_fetch, fw + 1); end
      nvec++; if (o_mem !== ((ld | st) ? mw + 1 : 0)) begin nerr++; $display("FAIL rnd%0d_mem ir=%h: got %0d want %0d", n, ins, o_mem, (ld | st) ? mw + 1 : 0); end
      nvec++; if (o_pcwe !== (ill ? 0 : 1)) begin nerr++; $display("FAIL rnd%0d_pcwe ir=%h: got %0d want %0d", n, ins, o_pcwe, ill ? 0 : 1); end
      nvec++; if (o_rfwe !== e_rfwe) begin nerr++; $display("FAIL rnd%0d_rfwe ir=%h: got %0d want %0d", n, ins, o_rfwe, e_rfwe); end
      if (e_rfwe == 1) begin
        nvec++; if (o_rfsel !== e_rfsel) begin nerr++; $display("FAIL rnd%0d_rfsel ir=%h: got %0d want %0d", n, ins, o_rfsel, e_rfsel); end
      end
      if (!ill) begin
        nvec++; if (o_cpcsel !== e_cpcsel) begin nerr++; $display("FAIL rnd%0d_pcsel ir=%h: got %0d want %0d", n, ins, o_cpcsel, e_cpcsel); end
        nvec++; if (s_alu !== 4'(e_alu)) begin nerr++; $display("FAIL rnd%0d_alu ir=%h: got %0d want %0d", n, ins, s_alu, e_alu); end
        nvec++; if (s_srca !== 2'(e_srca) || s_srcb !== 2'(e_srcb)) begin
          nerr++; $display("FAIL rnd%0d_src ir=%h: got %0d/%0d want %0d/%0d", n, ins, s_srca, s_srcb, e_srca, e_srcb);
        end
      end
      nvec++; if (o_ill !== (ill ? 1 : 0)) begin nerr++; $display("FAIL rnd%0d_illegal ir=%h: got %0d want %0d", n, ins, o_ill, ill ? 1 : 0); end
      nvec++; if (o_trap !== e_trap) begin nerr++; $display("FAIL rnd%0d_trap ir=%h: got %0d want %0d", n, ins, o_trap, e_trap); end
      if (e_trap == 1) begin
        nvec++; if (o_tpcsel !== 4) begin nerr++; $display("FAIL rnd%0d_trap_pcsel ir=%h: got %0d want 4", n, ins, o_tpcsel); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_intr();
    test_random();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
